// File: rtl/sdf_butterfly_stage_if.sv
// sdf_butterfly_stage_if: streaming sample bus into and out of an SDF butterfly stage
//   di_en/di_re/di_im      : input sample valid and complex value (master -> slave)
//   do_en/do_re/do_im      : output sample valid and complex value (slave -> master)
//   tw_en/tw_addr          : twiddle-required flag and twiddle index (slave -> master)
interface sdf_butterfly_stage_if #(
    parameter int WIDTH     = 16,
    parameter int LOG_DEPTH = 5
);
    logic                    di_en;
    logic signed [WIDTH-1:0] di_re;
    logic signed [WIDTH-1:0] di_im;
    logic                    do_en;
    logic signed [WIDTH-1:0] do_re;
    logic signed [WIDTH-1:0] do_im;
    logic                    tw_en;
    logic [LOG_DEPTH-1:0]    tw_addr;
    modport master (output di_en, di_re, di_im, input do_en, do_re, do_im, tw_en, tw_addr);
    modport slave  (input di_en, di_re, di_im, output do_en, do_re, do_im, tw_en, tw_addr);
endinterface

// File: rtl/sdf_butterfly_stage.sv
// sdf_butterfly_stage: radix-2 single-path delay-feedback DIF butterfly with a DEPTH-word feedback line
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of sdf_butterfly_stage_if (samples in; butterfly results, twiddle flag/index out)
module sdf_butterfly_stage #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 32,
    parameter int LOG_DEPTH = 5
) (
    input logic                  clock,
    input logic                  reset,
    sdf_butterfly_stage_if.slave bus
);
    localparam int CW = LOG_DEPTH + 1;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    primed_q, primed_d;
    logic [2*WIDTH-1:0]      mem_q [DEPTH];
    logic [2*WIDTH-1:0]      wr_d;
    logic                    phase;
    logic [LOG_DEPTH-1:0]    k;
    logic signed [WIDTH-1:0] y_re, y_im, sum_re, sum_im, dif_re, dif_im;
    logic                    do_en_q, do_en_d, tw_en_q, tw_en_d;
    logic signed [WIDTH-1:0] do_re_q, do_re_d, do_im_q, do_im_d;
    logic [LOG_DEPTH-1:0]    tw_addr_q, tw_addr_d;
    always_comb begin
        phase     = cnt_q[LOG_DEPTH];
        k         = cnt_q[LOG_DEPTH-1:0];
        {y_re, y_im} = mem_q[k];
        // Sign-extended WIDTH+1 add/sub, then keep bits [WIDTH:1]: floor halving that cannot overflow.
        sum_re    = WIDTH'(({y_re[WIDTH-1], y_re} + {bus.di_re[WIDTH-1], bus.di_re}) >> 1);
        sum_im    = WIDTH'(({y_im[WIDTH-1], y_im} + {bus.di_im[WIDTH-1], bus.di_im}) >> 1);
        dif_re    = WIDTH'(({y_re[WIDTH-1], y_re} - {bus.di_re[WIDTH-1], bus.di_re}) >> 1);
        dif_im    = WIDTH'(({y_im[WIDTH-1], y_im} - {bus.di_im[WIDTH-1], bus.di_im}) >> 1);
        cnt_d     = bus.di_en ? cnt_q + CW'(1) : cnt_q;
        // Primed once a whole frame has passed, so the unfilled delay line is never emitted.
        primed_d  = primed_q | (bus.di_en & (&cnt_q));
        do_en_d   = bus.di_en & (phase | primed_q);
        do_re_d   = !bus.di_en ? do_re_q : phase ? sum_re : y_re;
        do_im_d   = !bus.di_en ? do_im_q : phase ? sum_im : y_im;
        tw_en_d   = bus.di_en ? !phase : tw_en_q;
        tw_addr_d = !bus.di_en ? tw_addr_q : phase ? '0 : k;
        wr_d      = phase ? {dif_re, dif_im} : {bus.di_re, bus.di_im};
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            primed_q  <= 1'b0;
            do_en_q   <= 1'b0;
            do_re_q   <= '0;
            do_im_q   <= '0;
            tw_en_q   <= 1'b0;
            tw_addr_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            primed_q  <= primed_d;
            do_en_q   <= do_en_d;
            do_re_q   <= do_re_d;
            do_im_q   <= do_im_d;
            tw_en_q   <= tw_en_d;
            tw_addr_q <= tw_addr_d;
        end
    end
    // Delay line is deliberately left out of reset; priming hides its initial contents.
    always_ff @(posedge clock) begin
        if (bus.di_en) mem_q[k] <= wr_d;
    end
    assign bus.do_en   = do_en_q;
    assign bus.do_re   = do_re_q;
    assign bus.do_im   = do_im_q;
    assign bus.tw_en   = tw_en_q;
    assign bus.tw_addr = tw_addr_q;
endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// tb_sdf_butterfly_stage: directed and reference-model checks of the SDF butterfly stage (DEPTH=4)
module tb_sdf_butterfly_stage;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    sdf_butterfly_stage_if #(.WIDTH(16), .LOG_DEPTH(2)) bus();
    sdf_butterfly_stage #(.WIDTH(16), .DEPTH(4), .LOG_DEPTH(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );
    typedef struct {int re; int im; int te; int ta;} exp_t;
    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int fa[8] = '{100, 200, 300, 400, 20, 40, 60, 80};
    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic push(input int re, input int im, input int te, input int ta);
        exp_t e;
        e.re = re;
        e.im = im;
        e.te = te;
        e.ta = ta;
        q.push_back(e);
    endtask
    task automatic drive(input bit en, input int re, input int im);
        @(negedge clock);
        bus.di_en = en;
        bus.di_re = 16'(re);
        bus.di_im = 16'(im);
        @(posedge clock);
        #1;
        if (!en) check("gap_do_en", bus.do_en, 0);
    endtask
    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0);
    endtask
    task automatic do_reset();
        @(negedge clock);
        bus.di_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask
    always @(negedge clock) begin
        exp_t e;
        if (bus.do_en) begin
            if (q.size() == 0) check("unexpected_out", bus.do_en, 0);
            else begin
                e = q.pop_front();
                check("do_re", bus.do_re, e.re);
                check("do_im", bus.do_im, e.im);
                check("tw_en", bus.tw_en, e.te);
                check("tw_addr", bus.tw_addr, e.ta);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        int rr[3][8];
        int ri[3][8];
        int gaps[8] = '{0, 1, 0, 3, 2, 0, 3, 1};
        bus.di_en = 1'b0;
        bus.di_re = '0;
        bus.di_im = '0;
        #12;
        check("rst_do_en", bus.do_en, 0);
        check("rst_do_re", bus.do_re, 0);
        check("rst_do_im", bus.do_im, 0);
        check("rst_tw_en", bus.tw_en, 0);
        check("rst_tw_addr", bus.tw_addr, 0);
        @(negedge clock);
        reset = 1'b0;
        // Frame A back-to-back, then frames of zeros, rounding and saturation-free max values.
        for (int k = 0; k < 4; k++) push(60 * (k + 1), 0, 0, 0);
        for (int k = 0; k < 4; k++) push(40 * (k + 1), 0, 1, k);
        for (int k = 0; k < 4; k++) push(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) push(0, 0, 1, k);
        for (int k = 0; k < 4; k++) push(-2, 2, 0, 0);
        for (int k = 0; k < 4; k++) push(-2, 2, 1, k);
        for (int k = 0; k < 4; k++) push(32767, 0, 0, 0);
        for (int k = 0; k < 4; k++) push(0, 0, 1, k);
        for (int k = 0; k < 4; k++) push(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(1'b1, fa[i], 0);
        for (int i = 0; i < 8; i++) drive(1'b1, 0, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, -3, 5);
        for (int i = 0; i < 4; i++) drive(1'b1, 0, 0);
        for (int i = 0; i < 8; i++) drive(1'b1, 32767, 0);
        for (int i = 0; i < 8; i++) drive(1'b1, 0, 0);
        idle(2);
        check("drain_directed", q.size(), 0);
        // Same frame A with stall gaps, including 3-cycle gaps inside each half.
        do_reset();
        for (int k = 0; k < 4; k++) push(60 * (k + 1), 0, 0, 0);
        for (int k = 0; k < 4; k++) push(40 * (k + 1), 0, 1, k);
        for (int i = 0; i < 8; i++) begin
            idle(gaps[i]);
            drive(1'b1, fa[i], 0);
        end
        for (int k = 0; k < 4; k++) begin
            idle(k == 1 ? 3 : 1);
            drive(1'b1, 0, 0);
        end
        idle(2);
        check("drain_stall", q.size(), 0);
        // Reset in the middle of the second half, then a fresh unprimed frame.
        do_reset();
        push(60, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(1'b1, fa[i], 0);
        check("pre_reset_do_en", bus.do_en, 1);
        bus.di_en = 1'b0;
        reset = 1'b1;
        #1;
        check("async_reset_do_en", bus.do_en, 0);
        check("async_reset_do_re", bus.do_re, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) push(60 * (k + 1), 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(1'b1, fa[i], 0);
        idle(2);
        check("drain_midreset", q.size(), 0);
        // Three random frames against a frame-level reference model, drained with zeros.
        do_reset();
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++) begin
                rr[f][i] = int'($urandom_range(65535)) - 32768;
                ri[f][i] = int'($urandom_range(65535)) - 32768;
            end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++)
                push((rr[f][k] + rr[f][k+4]) >>> 1, (ri[f][k] + ri[f][k+4]) >>> 1, 0, 0);
            for (int k = 0; k < 4; k++)
                push((rr[f][k] - rr[f][k+4]) >>> 1, (ri[f][k] - ri[f][k+4]) >>> 1, 1, k);
        end
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++) drive(1'b1, rr[f][i], ri[f][i]);
        for (int i = 0; i < 4; i++) drive(1'b1, 0, 0);
        idle(2);
        check("drain_random", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
